// File: rtl/hps_ext_pkg.sv
// Shared EXT_BUS definitions: Groovy command codes, bus bit positions, master FSM states.
// No logic; constants, types and one helper function only.
// Imported by both the initiator and any responder built against this bus.
package hps_ext_pkg;

  // Groovy command set
  localparam logic [15:0] GET_GROOVY_STATUS = 16'h00F0;
  localparam logic [15:0] GET_GROOVY_HPS    = 16'h00F1;
  localparam logic [15:0] SET_INIT          = 16'h00F2;
  localparam logic [15:0] SET_SWITCHRES     = 16'h00F3;
  localparam logic [15:0] SET_BLIT          = 16'h00F4;
  localparam logic [15:0] SET_LOGO          = 16'h00F5;
  localparam logic [15:0] SET_AUDIO         = 16'h00F6;

  localparam logic [15:0] EXT_CMD_MIN = 16'h00F0;
  localparam logic [15:0] EXT_CMD_MAX = 16'h00F6;

  // EXT_BUS bit-field positions
  localparam int BUS_W        = 36;
  localparam int BUS_DOUT_LSB = 0;
  localparam int BUS_DOUT_MSB = 15;
  localparam int BUS_DIN_LSB  = 16;
  localparam int BUS_DIN_MSB  = 31;
  localparam int BUS_DOUT_EN  = 32;
  localparam int BUS_STROBE   = 33;
  localparam int BUS_ENABLE   = 34;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_SAMPLE,
    ST_GAP,
    ST_END,
    ST_DONE
  } ext_state_e;

  // True when the word falls inside the command range a responder understands
  function automatic logic is_ext_cmd(input logic [15:0] c);
    return (c >= EXT_CMD_MIN) && (c <= EXT_CMD_MAX);
  endfunction

endpackage

// File: rtl/hps_ext_master.sv
// EXT_BUS initiator: one command word plus 0..MAX_WORDS data words, captures io_dout after every strobe.
// Latency: 1 + 2*(N+1) + END_GAP + 1 cycles from accepted start to done (STROBE_GAP=1).
// No backpressure: start is accepted only while busy=0, otherwise dropped; responder must answer in one cycle.
module hps_ext_master
  import hps_ext_pkg::*;
#(
  parameter int MAX_WORDS  = 8,
  parameter int STROBE_GAP = 1,
  parameter int END_GAP    = 2
) (
  input  logic                     clk_sys,
  input  logic                     reset,
  inout  wire  [BUS_W-1:0]         EXT_BUS,
  input  logic                     start,
  input  logic [15:0]              cmd,
  input  logic [3:0]               num_words,
  input  logic [16*MAX_WORDS-1:0]  wr_data,
  output logic                     busy,
  output logic                     done,
  output logic                     nack,
  output logic [15:0]              status_word,
  output logic [16*MAX_WORDS-1:0]  rd_data
);

  localparam logic [3:0] MAX_CNT  = 4'(MAX_WORDS);
  localparam logic [7:0] GAP_LAST = 8'(STROBE_GAP - 2);
  localparam logic [7:0] END_LAST = 8'(END_GAP - 1);

  ext_state_e r_state;
  ext_state_e w_state_nxt;
  logic [3:0] r_idx;
  logic [3:0] w_idx_nxt;
  logic [7:0] r_wait_cnt;
  logic [7:0] w_wait_nxt;

  logic [15:0]             r_cmd;
  logic [3:0]              r_count;
  logic [16*MAX_WORDS-1:0] r_wr_data;
  logic [16*MAX_WORDS-1:0] r_rd_data;
  logic [15:0]             r_status;
  logic                    r_nack;
  logic [15:0]             r_din;

  logic        w_accept;
  logic        w_sample;
  logic        w_enable;
  logic        w_strobe;
  logic [15:0] w_din_sel;
  logic [3:0]  w_count_clamp;
  logic [15:0] w_bus_dout;
  logic        w_bus_dout_en;

  assign w_bus_dout    = EXT_BUS[BUS_DOUT_MSB:BUS_DOUT_LSB];
  assign w_bus_dout_en = EXT_BUS[BUS_DOUT_EN];

  assign EXT_BUS[BUS_DIN_MSB:BUS_DIN_LSB] = r_din;
  assign EXT_BUS[BUS_STROBE]              = w_strobe;
  assign EXT_BUS[BUS_ENABLE]              = w_enable;
  assign EXT_BUS[35]                      = 1'bz;

  assign w_count_clamp = (num_words > MAX_CNT) ? MAX_CNT : num_words;

  // FSM state, word index and wait counter registers
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_idx      <= '0;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_idx      <= w_idx_nxt;
      r_wait_cnt <= w_wait_nxt;
    end
  end

  // Next-state logic and bus control decode
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_wait_nxt  = r_wait_cnt;
    w_accept    = 1'b0;
    w_sample    = 1'b0;
    w_enable    = 1'b0;
    w_strobe    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_idx_nxt   = '0;
          w_state_nxt = ST_SETUP;
        end
      end
      ST_SETUP: begin
        w_enable    = 1'b1;
        w_state_nxt = ST_STROBE;
      end
      ST_STROBE: begin
        w_enable    = 1'b1;
        w_strobe    = 1'b1;
        w_state_nxt = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        w_enable = 1'b1;
        w_sample = 1'b1;
        // An unknown command aborts the data phase: nothing useful comes back
        if ((r_idx == 4'd0 && !w_bus_dout_en) || r_idx == r_count) begin
          w_wait_nxt  = '0;
          w_state_nxt = ST_END;
        end else begin
          w_idx_nxt = r_idx + 4'd1;
          if (STROBE_GAP > 1) begin
            w_wait_nxt  = '0;
            w_state_nxt = ST_GAP;
          end else begin
            w_state_nxt = ST_STROBE;
          end
        end
      end
      ST_GAP: begin
        w_enable = 1'b1;
        if (r_wait_cnt == GAP_LAST) begin
          w_state_nxt = ST_STROBE;
        end else begin
          w_wait_nxt = r_wait_cnt + 8'd1;
        end
      end
      ST_END: begin
        // io_enable low here is what resynchronises the responder
        if (r_wait_cnt == END_LAST) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_wait_nxt = r_wait_cnt + 8'd1;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Word presented on io_din for the upcoming strobe: command first, then data words
  always_comb begin
    w_din_sel = r_cmd;
    for (int w = 0; w < MAX_WORDS; w++) begin
      if (w_idx_nxt == 4'(w + 1)) begin
        w_din_sel = r_wr_data[16*w +: 16];
      end
    end
  end

  // Request latching, response capture and io_din staging
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_cmd     <= '0;
      r_count   <= '0;
      r_wr_data <= '0;
      r_rd_data <= '0;
      r_status  <= '0;
      r_nack    <= 1'b0;
      r_din     <= '0;
    end else begin
      if (w_accept) begin
        r_cmd     <= cmd;
        r_count   <= w_count_clamp;
        r_wr_data <= wr_data;
        r_rd_data <= '0;
        r_status  <= '0;
        r_nack    <= 1'b0;
      end
      if (w_sample) begin
        if (r_idx == 4'd0) begin
          r_status <= w_bus_dout;
          r_nack   <= ~w_bus_dout_en;
        end
        for (int w = 0; w < MAX_WORDS; w++) begin
          if (r_idx == 4'(w + 1)) begin
            r_rd_data[16*w +: 16] <= w_bus_dout;
          end
        end
      end
      if (w_state_nxt == ST_STROBE) begin
        r_din <= w_din_sel;
      end else if (w_state_nxt == ST_IDLE || w_state_nxt == ST_END) begin
        r_din <= '0;
      end
    end
  end

  assign busy        = (r_state != ST_IDLE) && (r_state != ST_DONE);
  assign done        = (r_state == ST_DONE);
  assign nack        = r_nack;
  assign status_word = r_status;
  assign rd_data     = r_rd_data;

endmodule

// File: tb/tb_hps_ext_master.sv
// Directed bench for hps_ext_master with a registered one-cycle EXT_BUS responder model.
module tb_hps_ext_master;
  import hps_ext_pkg::*;

  localparam int MW = 8;

  logic            clk_sys = 1'b0;
  logic            reset   = 1'b1;
  logic            start   = 1'b0;
  logic [15:0]     cmd     = '0;
  logic [3:0]      num_words = '0;
  logic [16*MW-1:0] wr_data = '0;
  logic            busy, done, nack;
  logic [15:0]     status_word;
  logic [16*MW-1:0] rd_data;
  wire  [35:0]     ext_bus;

  int checks   = 0;
  int failures = 0;
  int done_total = 0;

  always #5 clk_sys = ~clk_sys;

  hps_ext_master #(.MAX_WORDS(MW), .STROBE_GAP(1), .END_GAP(2)) dut (
    .clk_sys(clk_sys), .reset(reset), .EXT_BUS(ext_bus),
    .start(start), .cmd(cmd), .num_words(num_words), .wr_data(wr_data),
    .busy(busy), .done(done), .nack(nack),
    .status_word(status_word), .rd_data(rd_data)
  );

  // Responder model: registered, answers the word after each strobe
  logic [31:0] vga_frame = 32'h1234ABCD;
  logic [15:0] vcount    = 16'h0120;
  logic [15:0] rsp_dout = '0;
  logic        rsp_dout_en = 1'b0;
  logic        rsp_en_q = 1'b0;
  logic [15:0] rsp_rise = '0;
  logic [15:0] rsp_cnt = '0;
  logic [15:0] rsp_cmd = '0;
  logic        rsp_switchres = 1'b0;
  logic [15:0] rsp_sw_val = '0;

  assign ext_bus[15:0] = rsp_dout;
  assign ext_bus[32]   = rsp_dout_en;

  always @(posedge clk_sys) begin
    rsp_en_q <= ext_bus[BUS_ENABLE];
    if (ext_bus[BUS_ENABLE] && !rsp_en_q) rsp_rise <= rsp_rise + 16'd1;
    rsp_switchres <= 1'b0;
    if (!ext_bus[BUS_ENABLE]) begin
      rsp_cnt     <= '0;
      rsp_dout    <= '0;
      rsp_dout_en <= 1'b0;
    end else if (ext_bus[BUS_STROBE]) begin
      rsp_cnt <= rsp_cnt + 16'd1;
      if (rsp_cnt == 16'd0) begin
        rsp_cmd <= ext_bus[31:16];
        if (is_ext_cmd(ext_bus[31:16])) begin
          rsp_dout_en <= 1'b1;
          rsp_dout    <= rsp_rise;
        end else begin
          rsp_dout_en <= 1'b0;
          rsp_dout    <= '0;
        end
      end else begin
        rsp_dout <= '0;
        if (rsp_cmd == GET_GROOVY_STATUS) begin
          case (rsp_cnt)
            16'd1:   rsp_dout <= vga_frame[15:0];
            16'd2:   rsp_dout <= vga_frame[31:16];
            16'd3:   rsp_dout <= vcount;
            default: rsp_dout <= 16'h5A00 | (rsp_cnt - 16'd1);
          endcase
        end
        if (rsp_cmd == SET_SWITCHRES && rsp_cnt == 16'd1) begin
          rsp_switchres <= 1'b1;
          rsp_sw_val    <= ext_bus[31:16];
        end
      end
    end
  end

  always @(negedge clk_sys) begin
    if (done) done_total <= done_total + 1;
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One transaction from a start pulse to done; optional second start at cycle inject_cyc
  task automatic run_txn(input logic [15:0] c, input logic [3:0] n, input logic [127:0] wd,
                         input int inject_cyc, output int done_cyc, output int strobes, output int sw_cyc);
    done_cyc = 0; strobes = 0; sw_cyc = 0;
    @(negedge clk_sys);
    cmd = c; num_words = n; wr_data = wd; start = 1'b1;
    for (int cyc = 1; cyc <= 300; cyc++) begin
      @(negedge clk_sys);
      start = (cyc == inject_cyc);
      if (cyc == inject_cyc) begin
        cmd = SET_BLIT; num_words = 4'd8; wr_data = {8{16'hFFFF}};
      end
      if (ext_bus[BUS_STROBE]) strobes++;
      if (rsp_switchres && sw_cyc == 0) sw_cyc = cyc;
      if (done) begin
        done_cyc = cyc;
        break;
      end
    end
    start = 1'b0;
  endtask

  int dc, sc, swc, st, dbase;

  initial begin
    repeat (3) @(negedge clk_sys);
    check_eq("rst_enable", ext_bus[BUS_ENABLE], 0);
    check_eq("rst_strobe", ext_bus[BUS_STROBE], 0);
    check_eq("rst_din", ext_bus[31:16], 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_nack", nack, 0);
    check_eq("rst_status", status_word, 0);
    check_eq("rst_rd", rd_data, 0);
    reset = 1'b0;

    // GET_GROOVY_STATUS, 7 words
    run_txn(GET_GROOVY_STATUS, 4'd7, '0, 0, dc, sc, swc);
    check_eq("stat_done_cyc", dc, 20);
    check_eq("stat_strobes", sc, 8);
    check_eq("stat_nack", nack, 0);
    check_eq("stat_status", status_word, 16'd1);
    check_eq("stat_rd", rd_data, 128'h0000_5A06_5A05_5A04_5A03_0120_1234_ABCD);
    check_eq("stat_busy_at_done", busy, 0);

    // SET_SWITCHRES, 1 word
    run_txn(SET_SWITCHRES, 4'd1, 128'h0001, 0, dc, sc, swc);
    check_eq("swr_done_cyc", dc, 8);
    check_eq("swr_strobes", sc, 2);
    check_eq("swr_rise_cyc", swc, 5);
    check_eq("swr_din_word", rsp_sw_val, 16'h0001);
    check_eq("swr_nack", nack, 0);
    check_eq("swr_status", status_word, 16'd2);

    // Unknown command aborts after the command word
    run_txn(16'h0012, 4'd3, {8{16'h7777}}, 0, dc, sc, swc);
    check_eq("unk_strobes", sc, 1);
    check_eq("unk_nack", nack, 1);
    check_eq("unk_status", status_word, 0);
    check_eq("unk_rd", rd_data, 0);
    check_eq("unk_done_cyc", dc, 6);

    // Count above MAX_WORDS clamps to 8
    run_txn(GET_GROOVY_STATUS, 4'd12, '0, 0, dc, sc, swc);
    check_eq("clamp_strobes", sc, 9);
    check_eq("clamp_rd", rd_data, 128'h5A07_5A06_5A05_5A04_5A03_0120_1234_ABCD);
    check_eq("clamp_status", status_word, 16'd4);
    check_eq("clamp_done_cyc", dc, 22);

    // Second start while busy is ignored
    #1 dbase = done_total;
    run_txn(GET_GROOVY_STATUS, 4'd3, '0, 1, dc, sc, swc);
    repeat (12) @(negedge clk_sys);
    #1;
    check_eq("ign_strobes", sc, 4);
    check_eq("ign_done_cyc", dc, 12);
    check_eq("ign_rsp_cmd", rsp_cmd, GET_GROOVY_STATUS);
    check_eq("ign_rd", rd_data, 128'h0120_1234_ABCD);
    check_eq("ign_status", status_word, 16'd5);
    check_eq("ign_single_done", done_total - dbase, 1);
    check_eq("ign_busy", busy, 0);

    // Reset after the third strobe
    @(negedge clk_sys);
    cmd = GET_GROOVY_STATUS; num_words = 4'd7; wr_data = '0; start = 1'b1;
    st = 0;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      @(negedge clk_sys);
      start = 1'b0;
      if (ext_bus[BUS_STROBE]) st++;
      if (st == 3) break;
    end
    check_eq("mid_strobes", st, 3);
    check_eq("mid_busy", busy, 1);
    #1 dbase = done_total;
    reset = 1'b1;
    @(negedge clk_sys);
    check_eq("mrst_enable", ext_bus[BUS_ENABLE], 0);
    check_eq("mrst_strobe", ext_bus[BUS_STROBE], 0);
    check_eq("mrst_din", ext_bus[31:16], 0);
    check_eq("mrst_busy", busy, 0);
    check_eq("mrst_done", done, 0);
    check_eq("mrst_status", status_word, 0);
    check_eq("mrst_rd", rd_data, 0);
    check_eq("mrst_nack", nack, 0);
    reset = 1'b0;
    repeat (10) @(negedge clk_sys);
    #1;
    check_eq("mrst_no_done", done_total - dbase, 0);
    run_txn(GET_GROOVY_STATUS, 4'd2, '0, 0, dc, sc, swc);
    check_eq("post_done_cyc", dc, 10);
    check_eq("post_strobes", sc, 3);
    check_eq("post_rd", rd_data, 128'h1234_ABCD);
    check_eq("post_status", status_word, 16'd7);
    check_eq("post_nack", nack, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hps_ext_master.md
Name: hps_ext_master

Overview:
- Initiator end of the EXT_BUS command protocol. It drives io_enable, io_strobe and io_din, and captures io_dout and dout_en.
- Use 1: on-FPGA command sequencer for a responder in the same design.
- Use 2: bus-functional master in system benches for the Groovy command set (0xF0..0xF6).
- Each transaction is one command word followed by 0..MAX_WORDS data words. The word returned after every strobe is captured.

Parameters:
- MAX_WORDS, 8: maximum number of data words after the command word; sizes wr_data and rd_data.
- STROBE_GAP, 1: idle cycles between consecutive strobes. Minimum 1, so the responder's registered io_dout can be sampled.
- END_GAP, 2: cycles io_enable is held low after a transaction before done/ready.

Ports:
- clk_sys  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- EXT_BUS  inout  36  shared bus. Driven by this block: [31:16] io_din, [33] io_strobe, [34] io_enable. Read by this block: [15:0] io_dout, [32] dout_en. Bit [35] is left Z.
- start  in  1  single-cycle request; accepted only when busy=0.
- cmd  in  16  command word; latched on an accepted start.
- num_words  in  4  data-word count; latched; clamped to MAX_WORDS.
- wr_data  in  16*MAX_WORDS  data words, word k at [16k+15:16k]; latched on start.
- busy  out  1  high from the accepted start until done.
- done  out  1  one-cycle pulse at transaction end.
- nack  out  1  valid with done and held until next start; 1 = responder did not raise dout_en.
- status_word  out  16  io_dout captured after the command strobe.
- rd_data  out  16*MAX_WORDS  io_dout captured after data strobe k+1, stored as word k.

Behaviour:
- Reset values:
  - io_enable=0, io_strobe=0, io_din=0.
  - busy=0, done=0, nack=0, status_word=0, rd_data=0.
  - FSM in IDLE.
- Reset mid-transaction: all of the above next edge. io_enable falls, which resynchronises the responder. No done pulse is issued.
- FSM states: IDLE, SETUP, STROBE, SAMPLE, GAP, END, DONE.
- IDLE:
  - On start: latch cmd, num_words (min with MAX_WORDS) and wr_data.
  - Clear rd_data, status_word and nack; word index k=0; busy=1; go to SETUP.
- SETUP: io_enable=1 for one cycle with no strobe; go to STROBE.
- STROBE:
  - io_strobe=1 for exactly one cycle.
  - io_din = cmd when k=0, else wr_data word k-1.
  - Go to SAMPLE.
- SAMPLE (the cycle after the strobe): register EXT_BUS[15:0]. When k=0, also register EXT_BUS[32].
  - k=0: status_word <= io_dout. If dout_en=0: nack=1, go to END and skip remaining words.
  - k>=1: rd_data word k-1 <= io_dout.
  - If k == latched count: go to END. Otherwise k++ and go to GAP (or straight to STROBE if STROBE_GAP=1).
- GAP: STROBE_GAP-1 further idle cycles with io_enable=1 and io_strobe=0; then go to STROBE.
- io_din holds its last value between strobes; it is zeroed in IDLE and END.
- END: io_enable=0 for END_GAP cycles, then go to DONE.
- DONE: done=1 for one cycle and busy=0 in the same cycle; go to IDLE. A start in that cycle is ignored.
- start while busy=1 is ignored; latched inputs are not disturbed.
- num_words=0: command strobe and sample only; total strobes = 1.
- Timing with STROBE_GAP=1: strobe every 2 cycles. A full transaction is 1 + 2*(N+1) + END_GAP + 1 cycles from the start edge.
- dout_en sampled 0 after the command: the responder received an unknown command, and its io_dout is 0.
- No timeout: the responder is a registered slave with one-cycle response.

Decomposition:
- Shared package hps_ext_pkg holds:
  - Command codes GET_GROOVY_STATUS=0xF0, GET_GROOVY_HPS=0xF1, SET_INIT=0xF2, SET_SWITCHRES=0xF3, SET_BLIT=0xF4, SET_LOGO=0xF5, SET_AUDIO=0xF6.
  - EXT_CMD_MIN/MAX.
  - Bus bit-field positions: DOUT[15:0], DIN[31:16], DOUT_EN=32, STROBE=33, ENABLE=34.
  - The FSM state enum.
- The responder and this master both use the package.
- No sub-module; the tristate drive of EXT_BUS stays in this block.

Test Plan:
- GET_GROOVY_STATUS with responder model, vga_frame=0x1234ABCD, vcount=0x0120, num_words=7.
  - Response: status_word = responder rise count; rd_data words 0..1 = 0xABCD, 0x1234; word 2 = 0x0120.
  - Response: nack=0; done pulse at cycle 1+16+2+1=20 after start.
- SET_SWITCHRES, num_words=1, wr_data[0]=0x0001 -> responder cmd_switchres rises 1 cycle after the second strobe; nack=0.
- cmd=0x0012, num_words=3 -> exactly 1 strobe observed; nack=1; status_word=0; rd_data all 0; done pulse.
- num_words=12 with MAX_WORDS=8 -> exactly 9 strobes; rd_data word 7 is filled.
- Second start pulsed mid-transaction -> ignored; strobe count and latched cmd unchanged; single done.
- reset asserted after 3rd strobe -> next cycle io_enable=0, busy=0, outputs 0, no done. A new start then completes normally and the responder byte counter restarts at 0.
